// File: rtl/decode_lzs.sv
// LZS decompressor: parses a packed MSB-first bitstream into literals and matches,
// rebuilds bytes through a history window and packs them into 64-bit output words.
module decode_lzs #(
  parameter int LZF_WIDTH = 20,
  parameter int HIST_AW   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [63:0]          m_src,
  input  logic                 m_src_empty,
  input  logic                 m_last,
  output logic                 m_src_getn,
  input  logic                 fo_full,
  output logic [63:0]          m_dst,
  output logic                 m_dst_putn,
  output logic                 m_endn,
  output logic [LZF_WIDTH-1:0] out_cnt,
  output logic                 dec_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_TAG, S_LIT, S_OFF, S_LEN, S_EXT, S_COPY, S_FLUSH, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [127:0]         buf_q, buf_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 getn_q, getn_d;
  logic                 last_q, last_d;
  logic [HIST_AW-1:0]   off_q, off_d;
  logic [15:0]          len_q, len_d;
  logic                 s2_v_q, s2_v_d;
  logic                 fwd_q, fwd_d;
  logic [7:0]           fwd_dat_q, fwd_dat_d;
  logic [63:0]          pack_q, pack_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic                 wfull_q, wfull_d;
  logic [63:0]          dst_q, dst_d;
  logic                 putn_q, putn_d;
  logic                 endn_q, endn_d;
  logic [LZF_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 err_q, err_d;
  logic [HIST_AW-1:0]   wptr_q, wptr_d;

  logic [7:0]           hist_mem [0:(1<<HIST_AW)-1];
  logic [7:0]           hist_rd_q;
  logic                 ram_re, ram_we;
  logic [HIST_AW-1:0]   ram_raddr;
  logic [7:0]           ram_wdata;

  logic                 stall, capture, byte_v;
  logic [7:0]           byte_val, s2_byte;
  logic [7:0]           need, cons, cnt_rem;
  logic [HIST_AW-1:0]   off_val;

  assign stall   = fo_full;
  assign capture = ~getn_q;
  assign s2_byte = fwd_q ? fwd_dat_q : hist_rd_q;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    getn_d    = 1'b1;
    last_d    = last_q;
    off_d     = off_q;
    len_d     = len_q;
    s2_v_d    = s2_v_q;
    fwd_d     = fwd_q;
    fwd_dat_d = fwd_dat_q;
    pack_d    = pack_q;
    bcnt_d    = bcnt_q;
    wfull_d   = wfull_q;
    dst_d     = dst_q;
    putn_d    = 1'b1;
    endn_d    = 1'b1;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    wptr_d    = wptr_q;
    need      = 8'd0;
    cons      = 8'd0;
    cnt_rem   = 8'd0;
    byte_v    = 1'b0;
    byte_val  = 8'd0;
    off_val   = '0;
    ram_re    = 1'b0;
    ram_raddr = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'd0;

    // Second copy stage: the byte read last cycle leaves the pipeline now.
    if (!stall) begin
      s2_v_d = 1'b0;
      if (s2_v_q) begin
        byte_v   = 1'b1;
        byte_val = s2_byte;
      end
    end

    case (state_q)
      S_IDLE: if (cnt_q != 8'd0) state_d = S_TAG;
      S_TAG: begin
        need = 8'd1;
        if (!stall && cnt_q >= need) begin
          cons    = need;
          state_d = buf_q[127] ? S_OFF : S_LIT;
        end
      end
      S_LIT: begin
        need = 8'd8;
        if (!stall && cnt_q >= need) begin
          cons     = need;
          byte_v   = 1'b1;
          byte_val = buf_q[127:120];
          state_d  = S_TAG;
        end
      end
      S_OFF: begin
        need = (cnt_q == 8'd0) ? 8'd1 : (buf_q[127] ? 8'd8 : 8'd12);
        if (!stall && cnt_q >= need) begin
          cons    = need;
          off_val = buf_q[127] ? HIST_AW'(buf_q[126:120]) : HIST_AW'(buf_q[126:116]);
          off_d   = off_val;
          if (off_val == '0) begin
            if (buf_q[127]) state_d = S_FLUSH;
            else begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          end else if (LZF_WIDTH'(off_val) > out_cnt_q &&
                       out_cnt_q < LZF_WIDTH'(1 << HIST_AW)) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            state_d = S_LEN;
          end
        end
      end
      S_LEN: begin
        need = (cnt_q >= 8'd2 && buf_q[127:126] == 2'b11) ? 8'd4 : 8'd2;
        if (!stall && cnt_q >= need) begin
          cons    = need;
          state_d = S_COPY;
          case (buf_q[127:126])
            2'b00:   len_d = 16'd2;
            2'b01:   len_d = 16'd3;
            2'b10:   len_d = 16'd4;
            default: begin
              case (buf_q[125:124])
                2'b00:   len_d = 16'd5;
                2'b01:   len_d = 16'd6;
                2'b10:   len_d = 16'd7;
                default: begin
                  len_d   = 16'd8;
                  state_d = S_EXT;
                end
              endcase
            end
          endcase
        end
      end
      S_EXT: begin
        need = 8'd4;
        if (!stall && cnt_q >= need) begin
          cons  = need;
          len_d = len_q + 16'(buf_q[127:124]);
          if (buf_q[127:124] != 4'hf) state_d = S_COPY;
        end
      end
      S_COPY: begin
        if (!stall) begin
          // The byte in stage 2 is not yet in the RAM; offset 1 reads it via the bypass.
          ram_re    = 1'b1;
          ram_raddr = wptr_q + HIST_AW'(s2_v_q) - off_q;
          fwd_d     = s2_v_q && (ram_raddr == wptr_q);
          fwd_dat_d = s2_byte;
          s2_v_d    = 1'b1;
          len_d     = len_q - 16'd1;
          if (len_q == 16'd1) state_d = S_TAG;
        end
      end
      S_FLUSH: if (!stall) state_d = S_IDLE;
      S_ERR:   if (last_q && getn_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (need != 8'd0 && cnt_q < need && last_q && getn_q) begin
      err_d   = 1'b1;
      state_d = S_ERR;
    end

    cnt_rem = cnt_q - cons;
    buf_d   = buf_q << cons;
    cnt_d   = cnt_rem;
    if (capture) begin
      buf_d  = buf_d | ({m_src, 64'd0} >> cnt_rem);
      cnt_d  = cnt_rem + 8'd64;
      last_d = m_last;
      if (state_q == S_IDLE) out_cnt_d = '0;
    end

    if (getn_q && !last_q && !m_src_empty && cnt_q <= 8'd64 && state_q != S_FLUSH)
      getn_d = 1'b0;

    // A completed word is held until the next byte or the end marker decides its m_endn.
    if (byte_v) begin
      ram_we    = 1'b1;
      ram_wdata = byte_val;
      wptr_d    = wptr_q + HIST_AW'(1);
      if (out_cnt_q != '1) out_cnt_d = out_cnt_q + LZF_WIDTH'(1);
      if (wfull_q) begin
        dst_d   = pack_q;
        putn_d  = 1'b0;
        pack_d  = {byte_val, 56'd0};
        bcnt_d  = 3'd1;
        wfull_d = 1'b0;
      end else begin
        pack_d = pack_q | ({byte_val, 56'd0} >> {bcnt_q, 3'b000});
        if (bcnt_q == 3'd7) begin
          wfull_d = 1'b1;
          bcnt_d  = 3'd0;
        end else begin
          bcnt_d = bcnt_q + 3'd1;
        end
      end
    end

    if (state_q == S_FLUSH && !stall) begin
      if (bcnt_q != 3'd0 || wfull_q) begin
        dst_d  = pack_q;
        putn_d = 1'b0;
        endn_d = 1'b0;
      end
      pack_d  = '0;
      bcnt_d  = 3'd0;
      wfull_d = 1'b0;
      buf_d   = '0;
      cnt_d   = 8'd0;
      last_d  = 1'b0;
    end

    if (state_q == S_ERR) begin
      pack_d  = '0;
      bcnt_d  = 3'd0;
      wfull_d = 1'b0;
      buf_d   = '0;
      cnt_d   = 8'd0;
      if (last_q && getn_q) last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      cnt_q     <= 8'd0;
      getn_q    <= 1'b1;
      last_q    <= 1'b0;
      off_q     <= '0;
      len_q     <= 16'd0;
      s2_v_q    <= 1'b0;
      fwd_q     <= 1'b0;
      fwd_dat_q <= 8'd0;
      pack_q    <= '0;
      bcnt_q    <= 3'd0;
      wfull_q   <= 1'b0;
      dst_q     <= '0;
      putn_q    <= 1'b1;
      endn_q    <= 1'b1;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
      wptr_q    <= '0;
    end else if (ce) begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      getn_q    <= getn_d;
      last_q    <= last_d;
      off_q     <= off_d;
      len_q     <= len_d;
      s2_v_q    <= s2_v_d;
      fwd_q     <= fwd_d;
      fwd_dat_q <= fwd_dat_d;
      pack_q    <= pack_d;
      bcnt_q    <= bcnt_d;
      wfull_q   <= wfull_d;
      dst_q     <= dst_d;
      putn_q    <= putn_d;
      endn_q    <= endn_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
      wptr_q    <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      if (ram_we) hist_mem[wptr_q] <= ram_wdata;
      if (ram_re) hist_rd_q <= hist_mem[ram_raddr];
    end
  end

  // Strobes are masked while ce is low so a held-low strobe cannot pop or push twice.
  assign m_src_getn = getn_q | ~ce;
  assign m_dst_putn = putn_q | ~ce;
  assign m_endn     = endn_q | ~ce;
  assign m_dst      = dst_q;
  assign out_cnt    = out_cnt_q;
  assign dec_err    = err_q;

endmodule

// File: tb/tb_decode_lzs.sv
// Bench for decode_lzs: builds LZS bitstreams, feeds a show-ahead FIFO model and
// scoreboards every pushed output word against hand-derived expected words.
module tb_decode_lzs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b1;
  logic [63:0] m_src = 64'd0;
  logic        m_src_empty = 1'b1;
  logic        m_last = 1'b0;
  logic        m_src_getn;
  logic        fo_full = 1'b0;
  logic [63:0] m_dst;
  logic        m_dst_putn;
  logic        m_endn;
  logic [19:0] out_cnt;
  logic        dec_err;

  logic [64:0] in_q[$];
  logic [64:0] exp_q[$];
  logic        bits_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          push_cnt = 0;
  bit          ignore_out = 1'b0;

  decode_lzs #(.LZF_WIDTH(20), .HIST_AW(11)) dut (
    .clk(clk), .rst(rst), .ce(ce), .m_src(m_src), .m_src_empty(m_src_empty),
    .m_last(m_last), .m_src_getn(m_src_getn), .fo_full(fo_full), .m_dst(m_dst),
    .m_dst_putn(m_dst_putn), .m_endn(m_endn), .out_cnt(out_cnt), .dec_err(dec_err)
  );

  always #5 clk = ~clk;

  task automatic fifo_drive();
    if (in_q.size() > 0) begin
      m_src       = in_q[0][63:0];
      m_last      = in_q[0][64];
      m_src_empty = 1'b0;
    end else begin
      m_src       = 64'd0;
      m_last      = 1'b0;
      m_src_empty = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    logic [64:0] tmp;
    if (m_src_getn === 1'b0 && in_q.size() > 0) begin
      #1;
      tmp = in_q.pop_front();
      fifo_drive();
    end
  end

  always @(negedge clk) begin
    logic [64:0] e;
    if (rst && !ignore_out) begin
      if (m_endn === 1'b0) begin
        vectors++;
        if (m_dst_putn !== 1'b0) begin
          miscompares++;
          $display("FAIL endn_without_putn: m_dst_putn=%b, required 0", m_dst_putn);
        end
      end
      if (m_dst_putn === 1'b0) begin
        push_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_push: m_dst=%h m_endn=%b, required no push", m_dst, m_endn);
        end else begin
          e = exp_q.pop_front();
          if (m_dst !== e[63:0]) begin
            miscompares++;
            $display("FAIL m_dst: got %h, required %h", m_dst, e[63:0]);
          end
          vectors++;
          if (m_endn !== e[64]) begin
            miscompares++;
            $display("FAIL m_endn: got %b, required %b", m_endn, e[64]);
          end
        end
      end
    end
  end

  task automatic put_bits(input logic [31:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  task automatic put_lit(input logic [7:0] b);
    put_bits(32'({1'b0, b}), 9);
  endtask

  task automatic put_match7(input logic [6:0] off);
    put_bits(32'({2'b11, off}), 9);
  endtask

  task automatic put_match11(input logic [10:0] off);
    put_bits(32'({2'b10, off}), 13);
  endtask

  task automatic put_end();
    put_bits(32'h180, 9);
  endtask

  task automatic put_len(input int n);
    int rem;
    if (n <= 4) put_bits(32'(n - 2), 2);
    else if (n <= 7) put_bits(32'(12 + n - 5), 4);
    else begin
      put_bits(32'd15, 4);
      rem = n - 8;
      while (rem >= 15) begin
        put_bits(32'd15, 4);
        rem -= 15;
      end
      put_bits(32'(rem), 4);
    end
  endtask

  task automatic flush_stream();
    logic [63:0] w;
    @(negedge clk);
    while (bits_q.size() > 0) begin
      w = 64'd0;
      for (int i = 0; i < 64; i++)
        if (bits_q.size() > 0) w[63-i] = bits_q.pop_front();
      in_q.push_back({(bits_q.size() == 0), w});
    end
    fifo_drive();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL timeout: %0d outputs and %0d inputs pending, required 0", exp_q.size(), in_q.size());
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors += 6;
    if (m_src_getn !== 1'b1) begin miscompares++; $display("FAIL %s getn: got %b, required 1", tag, m_src_getn); end
    if (m_dst_putn !== 1'b1) begin miscompares++; $display("FAIL %s putn: got %b, required 1", tag, m_dst_putn); end
    if (m_endn !== 1'b1) begin miscompares++; $display("FAIL %s endn: got %b, required 1", tag, m_endn); end
    if (m_dst !== 64'd0) begin miscompares++; $display("FAIL %s m_dst: got %h, required 0", tag, m_dst); end
    if (out_cnt !== 20'd0) begin miscompares++; $display("FAIL %s out_cnt: got %0d, required 0", tag, out_cnt); end
    if (dec_err !== 1'b0) begin miscompares++; $display("FAIL %s dec_err: got %b, required 0", tag, dec_err); end
  endtask

  task automatic check_end(input string tag, input int cnt, input logic err);
    vectors += 2;
    if (out_cnt !== 20'(cnt)) begin
      miscompares++;
      $display("FAIL %s out_cnt: got %0d, required %0d", tag, out_cnt, cnt);
    end
    if (dec_err !== err) begin
      miscompares++;
      $display("FAIL %s dec_err: got %b, required %b", tag, dec_err, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fifo_drive();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_literals();
    for (int i = 1; i <= 8; i++) put_lit(8'(i));
    put_end();
    exp_q.push_back({1'b0, 64'h0102030405060708});
    flush_stream();
    wait_idle(400);
    check_end("literals", 8, 1'b0);
  endtask

  task automatic test_run();
    put_lit(8'h41);
    put_match7(7'd1);
    put_len(10);
    put_end();
    exp_q.push_back({1'b1, 64'h4141414141414141});
    exp_q.push_back({1'b0, 64'h4141410000000000});
    flush_stream();
    wait_idle(400);
    check_end("run", 11, 1'b0);
  endtask

  task automatic build_abcd();
    put_lit(8'h41); put_lit(8'h42); put_lit(8'h43); put_lit(8'h44);
    put_match11(11'd4);
    put_len(4);
    put_end();
    exp_q.push_back({1'b0, 64'h4142434441424344});
  endtask

  task automatic test_match11();
    build_abcd();
    flush_stream();
    wait_idle(400);
    check_end("match11", 8, 1'b0);
  endtask

  task automatic test_backpressure();
    int p0;
    build_abcd();
    flush_stream();
    repeat (4) @(negedge clk);
    fo_full = 1'b1;
    @(negedge clk);
    p0 = push_cnt;
    repeat (19) @(negedge clk);
    vectors++;
    if (push_cnt !== p0) begin
      miscompares++;
      $display("FAIL stall_pushes: got %0d pushes while full, required 0", push_cnt - p0);
    end
    vectors++;
    if (exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL stall_pending: got %0d words pending, required 1", exp_q.size());
    end
    fo_full = 1'b0;
    wait_idle(400);
    check_end("backpressure", 8, 1'b0);
  endtask

  task automatic test_error();
    int p0;
    p0 = push_cnt;
    put_lit(8'h61); put_lit(8'h62); put_lit(8'h63);
    put_match11(11'd5);
    put_len(2);
    put_bits(32'd0, 32); put_bits(32'd0, 32);
    put_bits(32'd0, 32); put_bits(32'd0, 32);
    flush_stream();
    wait_idle(400);
    repeat (10) @(negedge clk);
    check_end("error", 3, 1'b1);
    vectors++;
    if (push_cnt !== p0) begin
      miscompares++;
      $display("FAIL error_pushes: got %0d pushes, required 0", push_cnt - p0);
    end
  endtask

  task automatic test_reset_midcopy();
    put_lit(8'h41);
    put_match7(7'd1);
    put_len(200);
    put_end();
    ignore_out = 1'b1;
    flush_stream();
    repeat (40) @(negedge clk);
    rst = 1'b0;
    in_q.delete();
    exp_q.delete();
    fifo_drive();
    @(negedge clk);
    check_idle_outputs("midcopy_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ignore_out = 1'b0;
    @(negedge clk);
    test_literals();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_literals();
    test_run();
    test_match11();
    test_backpressure();
    test_error();
    test_reset_midcopy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
